// File: rtl/branch_fetch.sv
// Fetch stage with a 2-bit branch history table.
// PCs go to a synchronous instruction memory, predicted-taken branches redirect fetch, and branch/execute redirects override everything else.
module branch_fetch #(
  parameter int BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        b_is_hazard,
  input  logic [13:0] b_addr,
  input  logic        b_is_b_ope,
  input  logic        b_is_branch,
  input  logic [13:0] b_w_pc,
  output logic [13:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic        f_valid,
  output logic [13:0] f_pc,
  output logic [31:0] f_inst,
  output logic        f_pred
);

  localparam int BHT_SIZE = 1 << BHT_BITS;

  logic [13:0]         pc;
  logic [13:0]         d_pc;
  logic                d_valid;
  logic [1:0]          bht [BHT_SIZE];
  logic [5:0]          ope;
  logic                cond_br;
  logic                pred;
  logic [13:0]         target;
  logic [BHT_BITS-1:0] rd_idx;
  logic [BHT_BITS-1:0] wr_idx;
  logic                unused_bits;

  assign ope         = inst_data[31:26];
  assign cond_br     = (ope[1:0] == 2'b10) && (ope[5:4] != 2'b00);
  assign target      = inst_data[13:0];
  assign rd_idx      = d_pc[BHT_BITS-1:0];
  assign wr_idx      = b_w_pc[BHT_BITS-1:0];
  assign unused_bits = ^{inst_data[25:14], b_w_pc[13:BHT_BITS]};

  // The lookup reads the stored counter, so a same-cycle update is not visible yet.
  assign pred = d_valid && cond_br && bht[rd_idx][1];

  // While stalled, re-present the held address so inst_data keeps matching d_pc.
  assign inst_addr = stall ? d_pc : pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc      <= '0;
      d_pc    <= '0;
      d_valid <= 1'b0;
      f_valid <= 1'b0;
      f_pc    <= '0;
      f_inst  <= '0;
      f_pred  <= 1'b0;
    end else if (b_is_hazard) begin
      pc      <= b_addr;
      d_valid <= 1'b0;
      f_valid <= 1'b0;
    end else if (!stall) begin
      f_pc    <= d_pc;
      f_inst  <= inst_data;
      d_pc    <= pc;
      if (pred) begin
        // The fetch issued behind a taken branch is wrong-path and gets squashed.
        f_valid <= 1'b1;
        f_pred  <= 1'b1;
        pc      <= target;
        d_valid <= 1'b0;
      end else begin
        f_valid <= d_valid;
        f_pred  <= 1'b0;
        pc      <= pc + 14'd1;
        d_valid <= 1'b1;
      end
    end
  end

  // Counters train on every resolved branch, even while fetch is stalled or redirected.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BHT_SIZE; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (b_is_b_ope) begin
      if (b_is_branch) begin
        if (bht[wr_idx] != 2'b11) begin
          bht[wr_idx] <= bht[wr_idx] + 2'd1;
        end
      end else if (bht[wr_idx] != 2'b00) begin
        bht[wr_idx] <= bht[wr_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_fetch.sv
// Self-checking bench for branch_fetch.
// A behavioural fetch model is checked against directed scenarios and randomized traffic.
module tb_branch_fetch;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        stall = 1'b0;
  logic        b_is_hazard = 1'b0;
  logic [13:0] b_addr = '0;
  logic        b_is_b_ope = 1'b0;
  logic        b_is_branch = 1'b0;
  logic [13:0] b_w_pc = '0;
  logic [13:0] inst_addr;
  logic [31:0] inst_data;
  logic        f_valid;
  logic [13:0] f_pc;
  logic [31:0] f_inst;
  logic        f_pred;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];

  // Reference model state: next address to fetch, the address in flight, and the expected outputs.
  int          m_pc;
  int          m_dpc;
  bit          m_dvalid;
  logic [31:0] m_data;
  bit          e_valid;
  int          e_pc;
  logic [31:0] e_inst;
  bit          e_pred;
  int          bht [64];

  branch_fetch #(.BHT_BITS(6)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .b_is_hazard (b_is_hazard),
    .b_addr      (b_addr),
    .b_is_b_ope  (b_is_b_ope),
    .b_is_branch (b_is_branch),
    .b_w_pc      (b_w_pc),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .f_valid     (f_valid),
    .f_pc        (f_pc),
    .f_inst      (f_inst),
    .f_pred      (f_pred)
  );

  always #5 clk = ~clk;

  always @(posedge clk) inst_data <= mem[inst_addr];

  task automatic model_reset();
    m_pc = 0;
    m_dpc = 0;
    m_dvalid = 0;
    e_valid = 0;
    e_pc = 0;
    e_inst = '0;
    e_pred = 0;
    for (int i = 0; i < 64; i++) bht[i] = 1;
  endtask

  // Advance the model by one clock using the current inputs, then move past the edge.
  task automatic tick();
    logic [5:0] op;
    bit         is_cond;
    bit         taken;
    int         issue;
    int         idx;
    issue   = stall ? m_dpc : m_pc;
    op      = m_data[31:26];
    is_cond = (op % 4 == 2) && (op / 16 != 0);
    taken   = m_dvalid && is_cond && (bht[m_dpc % 64] >= 2);
    if (!rstn) begin
      model_reset();
    end else begin
      if (b_is_hazard) begin
        m_pc = int'(b_addr);
        m_dvalid = 0;
        e_valid = 0;
      end else if (!stall) begin
        e_pc = m_dpc;
        e_inst = m_data;
        e_valid = taken ? 1'b1 : m_dvalid;
        e_pred = taken;
        m_dpc = m_pc;
        m_pc = taken ? int'(m_data[13:0]) : (m_pc + 1) % 16384;
        m_dvalid = !taken;
      end
      if (b_is_b_ope) begin
        idx = int'(b_w_pc) % 64;
        if (b_is_branch) bht[idx] = (bht[idx] == 3) ? 3 : bht[idx] + 1;
        else             bht[idx] = (bht[idx] == 0) ? 0 : bht[idx] - 1;
      end
    end
    m_data = mem[issue];
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int pc, input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (f_valid === 1'b1 && f_pc === 14'(pc)) found = 1;
    end
  endtask

  task automatic redirect(input int addr);
    b_is_hazard = 1'b1;
    b_addr = 14'(addr);
    tick();
    b_is_hazard = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    #2;
    checks++;
    if (f_valid !== 1'b0 || f_pc !== 14'd0 || f_inst !== 32'd0 || f_pred !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got v=%b pc=%h inst=%h p=%b want all zero", f_valid, f_pc, f_inst, f_pred);
    end
    tick();
    tick();
    checks++;
    if (inst_addr !== 14'd0 || f_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held got addr=%h v=%b want addr=0 v=0", inst_addr, f_valid);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (inst_addr !== 14'd0) begin
      errors++;
      $display("[TB] FAIL release_addr got %h want 0", inst_addr);
    end
    tick();
    checks++;
    if (f_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_edge1 got f_valid=%b want 0", f_valid);
    end
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 14'd0 || f_pred !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_edge2 got v=%b pc=%h p=%b want v=1 pc=0 p=0", f_valid, f_pc, f_pred);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (f_valid !== 1'b1 || f_pc !== 14'(i) || f_inst !== mem[i] || f_pred !== 1'b0) begin
        errors++;
        $display("[TB] FAIL seq_pc%0d got v=%b pc=%h inst=%h p=%b want v=1 pc=%h inst=%h p=0", i, f_valid, f_pc, f_inst, f_pred, 14'(i), mem[i]);
      end
    end
  endtask

  task automatic test_prediction();
    bit found;
    mem[5] = {6'b010010, 12'h000, 14'h0020};
    // Four taken outcomes at an aliasing PC: 1 -> 2 -> 3 -> 3 -> 3.
    b_is_b_ope = 1'b1;
    b_is_branch = 1'b1;
    b_w_pc = 14'h45;
    for (int i = 0; i < 4; i++) tick();
    b_is_b_ope = 1'b0;
    redirect(0);
    run_until(5, 20, found);
    checks++;
    if (!found || f_pred !== 1'b1 || f_inst !== mem[5]) begin
      errors++;
      $display("[TB] FAIL pred_taken got found=%0d p=%b inst=%h want found=1 p=1 inst=%h", found, f_pred, f_inst, mem[5]);
    end
    tick();
    checks++;
    if (f_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pred_bubble got f_valid=%b want 0", f_valid);
    end
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 14'h20 || f_pred !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pred_target got v=%b pc=%h p=%b want v=1 pc=0020 p=0", f_valid, f_pc, f_pred);
    end
    // One not-taken outcome leaves the counter at 2, still predicting taken.
    b_is_b_ope = 1'b1;
    b_is_branch = 1'b0;
    b_w_pc = 14'h45;
    tick();
    b_is_b_ope = 1'b0;
    redirect(0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_dvalid && m_dpc == 5 && !stall) begin
        b_is_b_ope = 1'b1;
        b_is_branch = 1'b0;
        b_w_pc = 14'h5;
      end
      tick();
      b_is_b_ope = 1'b0;
      if (f_valid === 1'b1 && f_pc === 14'd5) found = 1;
    end
    checks++;
    if (!found || f_pred !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pred_same_cycle got found=%0d p=%b want found=1 p=1", found, f_pred);
    end
    // Counter is now 1; two more not-taken outcomes must saturate at 0, not wrap.
    b_is_b_ope = 1'b1;
    b_is_branch = 1'b0;
    b_w_pc = 14'h3fc5;
    tick();
    tick();
    b_is_b_ope = 1'b0;
    redirect(0);
    run_until(5, 20, found);
    checks++;
    if (!found || f_pred !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pred_saturate_low got found=%0d p=%b want found=1 p=0", found, f_pred);
    end
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 14'd6) begin
      errors++;
      $display("[TB] FAIL not_taken_next got v=%b pc=%h want v=1 pc=0006", f_valid, f_pc);
    end
    mem[5] = 32'h0000_0005;
  endtask

  task automatic test_hazard();
    bit found;
    bit bad;
    redirect(7);
    run_until(9, 20, found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL hazard_reach9 got timeout want f_pc=0009");
    end
    bad = 0;
    redirect(14'h100);
    if (f_valid === 1'b1) bad = 1;
    checks++;
    if (f_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hazard_squash got f_valid=%b want 0", f_valid);
    end
    tick();
    if (f_valid === 1'b1 && (f_pc === 14'd10 || f_pc === 14'd11)) bad = 1;
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 14'h100 || bad) begin
      errors++;
      $display("[TB] FAIL hazard_target got v=%b pc=%h wrongpath=%0d want v=1 pc=0100 wrongpath=0", f_valid, f_pc, bad);
    end
  endtask

  task automatic test_stall();
    bit found;
    redirect(6);
    run_until(7, 20, found);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (!found || f_valid !== 1'b1 || f_pc !== 14'd7 || f_inst !== mem[7] || inst_addr !== 14'(m_dpc)) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d got v=%b pc=%h addr=%h want v=1 pc=0007 addr=%h", i, f_valid, f_pc, inst_addr, 14'(m_dpc));
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 14'd8 || f_inst !== mem[8]) begin
      errors++;
      $display("[TB] FAIL stall_release got v=%b pc=%h inst=%h want v=1 pc=0008 inst=%h", f_valid, f_pc, f_inst, mem[8]);
    end
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 14'd9) begin
      errors++;
      $display("[TB] FAIL stall_after got v=%b pc=%h want v=1 pc=0009", f_valid, f_pc);
    end
  endtask

  task automatic test_stall_hazard();
    stall = 1'b1;
    b_is_hazard = 1'b1;
    b_addr = 14'h200;
    tick();
    stall = 1'b0;
    b_is_hazard = 1'b0;
    #1;
    checks++;
    if (inst_addr !== 14'h200 || f_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_hazard got addr=%h v=%b want addr=0200 v=0", inst_addr, f_valid);
    end
    tick();
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 14'h200) begin
      errors++;
      $display("[TB] FAIL stall_hazard_target got v=%b pc=%h want v=1 pc=0200", f_valid, f_pc);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) tick();
    rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (f_valid !== 1'b0 || f_pc !== 14'd0 || inst_addr !== 14'd0) begin
      errors++;
      $display("[TB] FAIL midreset_async got v=%b pc=%h addr=%h want 0 0 0", f_valid, f_pc, inst_addr);
    end
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if (f_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_glitch got f_valid=%b want 0", f_valid);
    end
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 14'd0) begin
      errors++;
      $display("[TB] FAIL midreset_first got v=%b pc=%h want v=1 pc=0000", f_valid, f_pc);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1024; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)
        mem[i] = {2'($urandom_range(1, 3)), 2'($urandom), 2'b10, 12'($urandom), 14'($urandom_range(0, 1023))};
      else if (r == 2)
        mem[i] = {2'b00, 2'($urandom), 2'b10, 26'($urandom)};
      else
        mem[i] = {6'($urandom_range(0, 63) & 6'h3d), 26'($urandom)};
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      stall = ($urandom_range(0, 9) < 3);
      b_is_hazard = ($urandom_range(0, 19) == 0);
      b_addr = ($urandom_range(0, 7) == 0) ? 14'(16381) : 14'($urandom_range(0, 1023));
      b_is_b_ope = ($urandom_range(0, 2) == 0);
      b_is_branch = ($urandom_range(0, 2) != 0);
      b_w_pc = 14'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rstn = 1'b0;
        model_reset();
      end
      tick();
      rstn = 1'b1;
      checks++;
      if (f_valid !== e_valid || f_pred !== e_pred) begin
        errors++;
        $display("[TB] FAIL rand_flags cyc %0d got v=%b p=%b want v=%b p=%b", cyc, f_valid, f_pred, e_valid, e_pred);
      end
      checks++;
      if (f_pc !== 14'(e_pc) || f_inst !== e_inst) begin
        errors++;
        $display("[TB] FAIL rand_data cyc %0d got pc=%h inst=%h want pc=%h inst=%h", cyc, f_pc, f_inst, 14'(e_pc), e_inst);
      end
      checks++;
      if (inst_addr !== 14'(stall ? m_dpc : m_pc)) begin
        errors++;
        $display("[TB] FAIL rand_addr cyc %0d got %h want %h", cyc, inst_addr, 14'(stall ? m_dpc : m_pc));
      end
    end
    stall = 1'b0;
    b_is_hazard = 1'b0;
    b_is_b_ope = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom & 32'h03ff_ffff;
    m_data = '0;
    #1;
    test_reset();
    test_sequential();
    test_prediction();
    test_hazard();
    test_stall();
    test_stall_hazard();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
